// File: rtl/txpause_gate.sv
// TX pause gate: holds off new AXI-Stream frames while the link partner requests a pause,
// with a full-throughput output/skid register slice and saturating pause statistics.
module txpause_gate #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_tx_pause_enable,
    input  logic              rx_pause_active,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              m_axis_tready,
    output logic              tx_paused,
    input  logic              stat_clear,
    output logic [CNT_W-1:0]  stat_pause_events,
    output logic [CNT_W-1:0]  stat_paused_cycles
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRAME  = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } beat_t;

    state_t           state_q, state_d;
    logic             pause_req_q, pause_req_d;
    beat_t            out_q, out_d, skid_q, skid_d, in_beat;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] events_q, events_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             gate_open;
    logic             accept;
    logic             out_ready;

    // Gate only closes between frames; the skid entry must be free to take a beat.
    assign gate_open     = (state_q == S_FRAME) || ((state_q == S_IDLE) && !pause_req_q);
    assign s_axis_tready = gate_open && !skid_valid_q && !rst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign in_beat       = '{data: s_axis_tdata, keep: s_axis_tkeep,
                             last: s_axis_tlast, user: s_axis_tuser};

    always_comb begin
        state_d     = state_q;
        pause_req_d = rx_pause_active & cfg_tx_pause_enable;
        case (state_q)
            S_IDLE: begin
                if (pause_req_q) begin
                    state_d = S_PAUSED;
                end else if (accept && !s_axis_tlast) begin
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (accept && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_PAUSED: begin
                if (!pause_req_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register with one-entry skid; the skid refills the output first when it drains.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        out_ready    = !out_valid_q || m_axis_tready;
        if (out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = in_beat;
                end
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_comb begin
        events_d = events_q;
        cycles_d = cycles_q;
        if (stat_clear) begin
            events_d = '0;
            cycles_d = '0;
        end else begin
            if ((state_q == S_IDLE) && (state_d == S_PAUSED) && (events_q != '1)) begin
                events_d = events_q + CNT_W'(1);
            end
            if ((state_q == S_PAUSED) && (cycles_q != '1)) begin
                cycles_d = cycles_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pause_req_q  <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            events_q     <= '0;
            cycles_q     <= '0;
        end else begin
            state_q      <= state_d;
            pause_req_q  <= pause_req_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            events_q     <= events_d;
            cycles_q     <= cycles_d;
        end
    end

    assign m_axis_tdata       = out_q.data;
    assign m_axis_tkeep       = out_q.keep;
    assign m_axis_tlast       = out_q.last;
    assign m_axis_tuser       = out_q.user;
    assign m_axis_tvalid      = out_valid_q;
    assign tx_paused          = (state_q == S_PAUSED);
    assign stat_pause_events  = events_q;
    assign stat_paused_cycles = cycles_q;

endmodule

// File: tb/tb_txpause_gate.sv
// Self-checking bench for txpause_gate: vector table for gate behaviour, hand sequences for
// pause timing/statistics/reset, and a scoreboard over every beat through the slice.
module tb_txpause_gate;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SAT_W  = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_tx_pause_enable;
    logic              rx_pause_active;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tuser;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              m_axis_tready;
    logic              tx_paused;
    logic              stat_clear;
    logic [CNT_W-1:0]  stat_pause_events;
    logic [CNT_W-1:0]  stat_paused_cycles;

    logic              sat_s_tready;
    logic [DATA_W-1:0] sat_m_tdata;
    logic [KEEP_W-1:0] sat_m_tkeep;
    logic              sat_m_tvalid;
    logic              sat_m_tlast;
    logic              sat_m_tuser;
    logic              sat_tx_paused;
    logic [SAT_W-1:0]  sat_events;
    logic [SAT_W-1:0]  sat_cycles;

    always #5 clk = ~clk;

    txpause_gate #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_tx_pause_enable(cfg_tx_pause_enable), .rx_pause_active(rx_pause_active),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .tx_paused(tx_paused), .stat_clear(stat_clear),
        .stat_pause_events(stat_pause_events), .stat_paused_cycles(stat_paused_cycles)
    );

    // Narrow-counter copy driven by the same stimulus, used only for saturation checks.
    txpause_gate #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst),
        .cfg_tx_pause_enable(cfg_tx_pause_enable), .rx_pause_active(rx_pause_active),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(sat_s_tready),
        .m_axis_tdata(sat_m_tdata), .m_axis_tkeep(sat_m_tkeep), .m_axis_tvalid(sat_m_tvalid),
        .m_axis_tlast(sat_m_tlast), .m_axis_tuser(sat_m_tuser), .m_axis_tready(m_axis_tready),
        .tx_paused(sat_tx_paused), .stat_clear(stat_clear),
        .stat_pause_events(sat_events), .stat_paused_cycles(sat_cycles)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } beat_t;

    typedef struct packed {
        logic en;
        logic rx;
        logic v;
        logic l;
        logic exp_rdy;
        logic exp_pause;
    } vec_t;

    beat_t exp_q[$];
    beat_t m_beat, s_beat, prev_beat;
    logic  prev_stall;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    seq     = 1;

    assign m_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    assign s_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop the departing beat before pushing the arriving one.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_hold", 64'(m_beat == prev_beat), 64'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("sb_data", m_axis_tdata, e.data);
                    check("sb_keep", 64'(m_axis_tkeep), 64'(e.keep));
                    check("sb_last_user", 64'({m_axis_tlast, m_axis_tuser}), 64'({e.last, e.user}));
                end
            end
            if (s_axis_tvalid && s_axis_tready) exp_q.push_back(s_beat);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = m_beat;
        end
    end

    task automatic set_beat();
        s_axis_tdata = {32'(seq), ~32'(seq)};
        s_axis_tkeep = KEEP_W'(seq * 37 + 1);
        s_axis_tuser = seq[0];
        seq++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        stat_clear = 1'b1;
        next_cycle();
        stat_clear = 1'b0;
    endtask

    task automatic drive_frame(input int n, input int pause_at, output int cycles);
        int   b;
        logic acc;
        b      = 0;
        cycles = 0;
        while (b < n && cycles < 200) begin
            set_beat();
            s_axis_tlast  = (b == n - 1);
            s_axis_tvalid = 1'b1;
            if (b == pause_at) rx_pause_active = 1'b1;
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            next_cycle();
            cycles++;
            if (acc) b++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (b < n) check("frame_timeout", 64'(b), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        int   cyc;
        int   k;
        int   beats;
        int   left;
        int   cycles;
        logic acc;
        logic need_new;

        // en, rx, tvalid, tlast, expected tready, expected tx_paused
        tbl[0]  = '{H, L, H, H, H, L};
        tbl[1]  = '{H, L, H, L, H, L};
        tbl[2]  = '{H, H, H, L, H, L};
        tbl[3]  = '{H, H, H, H, H, L};
        tbl[4]  = '{H, H, H, L, L, L};
        tbl[5]  = '{H, H, H, L, L, H};
        tbl[6]  = '{H, L, H, L, L, H};
        tbl[7]  = '{H, L, H, L, L, H};
        tbl[8]  = '{H, L, H, H, H, L};
        tbl[9]  = '{L, H, H, H, H, L};
        tbl[10] = '{L, H, H, H, H, L};
        tbl[11] = '{H, H, L, L, H, L};
        tbl[12] = '{L, H, L, L, L, L};
        tbl[13] = '{L, H, L, L, L, H};
        tbl[14] = '{L, H, H, H, H, L};

        rst = 1'b1;
        cfg_tx_pause_enable = 1'b0;
        rx_pause_active = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
        m_axis_tready = 1'b0;
        stat_clear = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_data", m_axis_tdata, 64'd0);
        check("rst_paused", 64'(tx_paused), 64'd0);
        check("rst_events", 64'(stat_pause_events), 64'd0);
        check("rst_cycles", 64'(stat_paused_cycles), 64'd0);
        next_cycle();
        rst = 1'b0;
        m_axis_tready = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cfg_tx_pause_enable = tbl[i].en;
            rx_pause_active     = tbl[i].rx;
            s_axis_tvalid       = tbl[i].v;
            s_axis_tlast        = tbl[i].l;
            set_beat();
            @(negedge clk);
            check($sformatf("vec%0d_tready", i), 64'(s_axis_tready), 64'(tbl[i].exp_rdy));
            check($sformatf("vec%0d_paused", i), 64'(tx_paused), 64'(tbl[i].exp_pause));
            next_cycle();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        cfg_tx_pause_enable = 1'b1;
        rx_pause_active = 1'b0;
        repeat (3) next_cycle();
        pulse_clear();

        // Pass-through frames of 1, 2 and 9 beats
        foreach (tbl[i]) begin
            if (i < 3) begin
                drive_frame((i == 0) ? 1 : (i == 1) ? 2 : 9, -1, cyc);
                check($sformatf("pass%0d_cycles", i), 64'(cyc), 64'((i == 0) ? 1 : (i == 1) ? 2 : 9));
                @(negedge clk);
                check($sformatf("pass%0d_lat_valid", i), 64'({m_axis_tvalid, m_axis_tlast}), 64'b11);
                next_cycle();
            end
        end
        check("pass_events", 64'(stat_pause_events), 64'd0);
        check("pass_cycles", 64'(stat_paused_cycles), 64'd0);

        // Pause raised mid-frame: frame completes, next frame is held
        drive_frame(8, 2, cyc);
        check("midpause_cycles", 64'(cyc), 64'd8);
        set_beat();
        s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b1;
        @(negedge clk);
        check("midpause_blocked", 64'(s_axis_tready), 64'd0);
        check("midpause_paused0", 64'(tx_paused), 64'd0);
        next_cycle();
        @(negedge clk);
        check("midpause_paused1", 64'(tx_paused), 64'd1);
        check("midpause_events", 64'(stat_pause_events), 64'd1);
        s_axis_tvalid = 1'b0;
        rx_pause_active = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("midpause_release", 64'(tx_paused), 64'd0);
        next_cycle();

        // Idle pause for 20 cycles, counters and saturation
        pulse_clear();
        rx_pause_active = 1'b1;
        @(negedge clk);
        check("idle_paused_e0", 64'(tx_paused), 64'd0);
        next_cycle();
        set_beat();
        s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b1;
        @(negedge clk);
        check("idle_paused_e1", 64'(tx_paused), 64'd0);
        check("idle_tready_e1", 64'(s_axis_tready), 64'd0);
        next_cycle();
        @(negedge clk);
        check("idle_paused_e2", 64'(tx_paused), 64'd1);
        repeat (18) @(posedge clk);
        #1;
        rx_pause_active = 1'b0;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (s_axis_tready) break;
            next_cycle();
            k++;
        end
        check("idle_accept_delay", 64'(k), 64'd2);
        next_cycle();
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("idle_cycles", 64'(stat_paused_cycles), 64'd20);
        check("idle_events", 64'(stat_pause_events), 64'd1);
        check("sat_cycles", 64'(sat_cycles), 64'd15);
        check("sat_events", 64'(sat_events), 64'd1);
        next_cycle();
        pulse_clear();
        @(negedge clk);
        check("clear_cycles", 64'(stat_paused_cycles), 64'd0);
        check("clear_events", 64'(stat_pause_events), 64'd0);
        check("clear_sat_cycles", 64'(sat_cycles), 64'd0);
        next_cycle();

        // Pause disabled: request ignored
        cfg_tx_pause_enable = 1'b0;
        rx_pause_active = 1'b1;
        drive_frame(5, -1, cyc);
        check("noen_cycles", 64'(cyc), 64'd5);
        @(negedge clk);
        check("noen_paused", 64'(tx_paused), 64'd0);
        check("noen_counters", 64'({stat_pause_events, stat_paused_cycles}), 64'd0);
        next_cycle();
        cfg_tx_pause_enable = 1'b1;
        rx_pause_active = 1'b0;

        // Random backpressure with toggling pause
        beats = 0;
        cycles = 0;
        left = 0;
        need_new = 1'b1;
        while (beats < 200 && cycles < 5000) begin
            if (need_new) begin
                if (left == 0) left = $urandom_range(1, 6);
                set_beat();
                s_axis_tlast = (left == 1);
            end
            s_axis_tvalid = 1'b1;
            m_axis_tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rx_pause_active = ~rx_pause_active;
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            next_cycle();
            cycles++;
            need_new = acc;
            if (acc) begin
                beats++;
                left--;
            end
        end
        check("rand_beats", 64'(beats), 64'd200);
        s_axis_tvalid = 1'b0;
        rx_pause_active = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) next_cycle();
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) next_cycle();

        // Reset mid-frame with beats buffered
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b0;
        repeat (3) begin
            set_beat();
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", 64'(s_axis_tready), 64'd0);
        next_cycle();
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_m_data", m_axis_tdata, 64'd0);
        check("midrst_m_side", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'd0);
        check("midrst_paused", 64'(tx_paused), 64'd0);
        check("midrst_counters", 64'({stat_pause_events, stat_paused_cycles}), 64'd0);
        check("midrst_tready_back", 64'(s_axis_tready), 64'd1);
        rx_pause_active = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("midrst_idle_state", 64'(tx_paused), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
